// File: rtl/cache_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_request_arbiter
// Purpose  : Shares the single access port of the 4-way set-associative cache
//            among NUM_REQ requesters. A round-robin arbiter picks one
//            requester. A transaction sequencer latches its opcode, address and
//            write byte, strobes the cache, samples hit/miss, waits out the miss
//            penalty and returns a done pulse. Completed hits and misses are
//            counted with saturating counters.
// Ports    : clk, rst_b (async, active-low)
//            i_req/i_req_opcode/i_req_addr/i_req_wdata : requester side (packed)
//            o_grant/o_done/o_done_hit/o_busy          : requester status
//            o_address_word/o_try_read/o_try_write/o_write_data, i_hit_miss
//                                                      : cache port
//            o_hit_count/o_miss_count                  : statistics
// Revision : 1.0 - initial release
// ============================================================================
module cache_request_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int MISS_PENALTY      = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_b,
    input  logic [NUM_REQ-1:0]                   i_req,
    input  logic [NUM_REQ-1:0]                   i_req_opcode,
    input  logic [NUM_REQ*ADDRESS_WORD_SIZE-1:0] i_req_addr,
    input  logic [NUM_REQ*8-1:0]                 i_req_wdata,
    output logic [NUM_REQ-1:0]                   o_grant,
    output logic                                 o_done,
    output logic                                 o_done_hit,
    output logic                                 o_busy,
    output logic [ADDRESS_WORD_SIZE-1:0]         o_address_word,
    output logic                                 o_try_read,
    output logic                                 o_try_write,
    output logic [7:0]                           o_write_data,
    input  logic                                 i_hit_miss,
    output logic [15:0]                          o_hit_count,
    output logic [15:0]                          o_miss_count
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = $clog2(MISS_PENALTY + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_CHECK    = 3'd2,
        S_STALL    = 3'd3,
        S_COMPLETE = 3'd4
    } state_t;

    state_t                         r_state;
    logic [c_IDX_W-1:0]             r_ptr;
    logic [c_IDX_W-1:0]             r_idx;
    logic [c_CNT_W-1:0]             r_stall_cnt;
    logic [NUM_REQ-1:0]             r_grant;
    logic                           r_done;
    logic                           r_done_hit;
    logic [ADDRESS_WORD_SIZE-1:0]   r_addr;
    logic [7:0]                     r_wdata;
    logic                           r_try_read;
    logic                           r_try_write;
    logic [15:0]                    r_hit_count;
    logic [15:0]                    r_miss_count;

    // ------------------------------------------------------------------
    // Round-robin pick: first set request starting at r_ptr, wrapping.
    // One extra bit on the running sum lets non-power-of-two NUM_REQ wrap.
    // ------------------------------------------------------------------
    logic                           w_found;
    logic [c_IDX_W-1:0]             w_sel_idx;
    logic [c_IDX_W:0]               w_sum;

    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_sum     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (c_IDX_W+1)'(i);
            if (w_sum >= (c_IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_sum[c_IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_sel_idx = w_sum[c_IDX_W-1:0];
            end
        end
    end

    logic                           w_sel_op;
    logic [ADDRESS_WORD_SIZE-1:0]   w_sel_addr;
    logic [7:0]                     w_sel_wdata;

    assign w_sel_op    = i_req_opcode[w_sel_idx];
    assign w_sel_addr  = i_req_addr[w_sel_idx*ADDRESS_WORD_SIZE +: ADDRESS_WORD_SIZE];
    assign w_sel_wdata = i_req_wdata[w_sel_idx*8 +: 8];

    // ------------------------------------------------------------------
    // Sequencer. Every output is a register so nothing combinational
    // reaches the ports from the inputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_idx        <= '0;
            r_stall_cnt  <= '0;
            r_grant      <= '0;
            r_done       <= 1'b0;
            r_done_hit   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_try_read   <= 1'b0;
            r_try_write  <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            // Strobes and done are single-cycle by default.
            r_try_read  <= 1'b0;
            r_try_write <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx       <= w_sel_idx;
                        r_grant     <= NUM_REQ'(1) << w_sel_idx;
                        r_addr      <= w_sel_addr;
                        r_wdata     <= w_sel_wdata;
                        r_try_read  <= ~w_sel_op;
                        r_try_write <= w_sel_op;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (i_hit_miss) begin
                        r_done     <= 1'b1;
                        r_done_hit <= 1'b1;
                        r_state    <= S_COMPLETE;
                    end else begin
                        r_stall_cnt <= c_CNT_W'(MISS_PENALTY);
                        r_state     <= S_STALL;
                    end
                end
                S_STALL: begin
                    // Loaded with MISS_PENALTY, leaves on 1: exactly
                    // MISS_PENALTY cycles spent here.
                    if (r_stall_cnt == c_CNT_W'(1)) begin
                        r_done     <= 1'b1;
                        r_done_hit <= 1'b0;
                        r_state    <= S_COMPLETE;
                    end else begin
                        r_stall_cnt <= r_stall_cnt - c_CNT_W'(1);
                    end
                end
                S_COMPLETE: begin
                    if (r_done_hit) begin
                        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
                    end else begin
                        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
                    end
                    r_ptr      <= (r_idx == c_IDX_W'(NUM_REQ-1)) ? '0 : r_idx + c_IDX_W'(1);
                    r_grant    <= '0;
                    r_addr     <= '0;
                    r_wdata    <= '0;
                    r_done_hit <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_grant        = r_grant;
    assign o_done         = r_done;
    assign o_done_hit     = r_done & r_done_hit;
    assign o_busy         = (r_state != S_IDLE);
    assign o_address_word = r_addr;
    assign o_try_read     = r_try_read;
    assign o_try_write    = r_try_write;
    assign o_write_data   = r_wdata;
    assign o_hit_count    = r_hit_count;
    assign o_miss_count   = r_miss_count;

endmodule
`default_nettype wire
